timer_bridge: RTL and testbench
===============================

# timer_bridge

Bus bridge and interrupt controller between the pipelined CPU's memory stage and two timer peripherals. It decodes each CPU peripheral access and sequences it onto the addressed timer as a fixed-length read or write transaction with a ready handshake. It also edge-latches the timer IRQ lines into a maskable pending register and drives the hardware-interrupt vector seen by CP0.

## Interface
- BASE, 32'h0000_7F00, base of the peripheral window; bits [31:6] are compared.
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-low: state is reset on a posedge where clr==0.
- PrAddr  in  32  CPU byte address; bits [1:0] ignored.
- PrWD  in  32  CPU write data.
- PrRE  in  1  read request; held until PrReady.
- PrWE  in  1  write request; held until PrReady; wins if PrRE is also high.
- PrRD  out  32  read data; valid while PrReady==1.
- PrReady  out  1  one-cycle transaction-complete pulse.
- DEV_WD  out  32  write data to both timers (PrWD, registered at accept).
- DEV_ADD  out  2  timer register select [3:2], shared.
- DEV0_WE, DEV1_WE  out  1  per-timer write strobes.
- DEV0_RD, DEV1_RD  in  32  timer read data (combinational in the timer).
- DEV0_IRQ, DEV1_IRQ  in  1  timer interrupt lines (level).
- HWInt  out  6  interrupt vector to CP0: {4'b0, pending[1:0] & mask[1:0]}.

## Operation
- Address map (offset from BASE): 0x00-0x0B timer0 (CTRL/PRESET/COUNT); 0x10-0x1B timer1; 0x20 STATUS (RO): [1:0] pending, [8] err; 0x24 MASK (RW): [1:0]; 0x28 ACK (WO): write-1-to-clear, [1:0] pending, [8] err. All other offsets, and any address outside the BASE window, are unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if PrWE or PrRE, latch addr, data, dir and target, then go to ACCESS. Otherwise stay.
- ACCESS (1 cycle):
  - Write to a timer: drive DEVn_WE=1 with DEV_ADD=addr[3:2].
  - Read from a timer: capture DEVn_RD into the PrRD register.
  - Internal register: perform the read or write.
  - Unmapped: no strobe, PrRD<=0, set err.
  - Next state is RESP.
- RESP (1 cycle): PrReady=1, then go to IDLE. A request still high in this cycle is not re-accepted until IDLE. The CPU must drop it on PrReady.
- Writes to timer offset 0x08 (COUNT, read-only) are forwarded; the timer ignores them.
- Interrupt capture:
  - irq_q[n] registers DEVn_IRQ every cycle.
  - A rising edge (DEVn_IRQ & ~irq_q[n]) sets pending[n].
  - ACK bit n clears pending[n]. Set wins over a same-cycle clear.
  - A held-high IRQ does not re-set a pending bit after it is acked.
- MASK gates HWInt only. Pending bits latch regardless of mask, and unmasking later asserts HWInt.
- Reset mid-transaction aborts it: no strobe and no PrReady are issued.

## Timing
- Reset values: PrRD=0, PrReady=0, DEV0_WE=DEV1_WE=0, DEV_ADD=0, DEV_WD=0, HWInt=0, pending=0, mask=0, err=0, irq_q=0, state=IDLE.
- Latency: request seen in IDLE at cycle t, strobe/capture at t+1, PrReady at t+2, IDLE at t+3. Back-to-back throughput is 1 access per 3 cycles.
- DEVn_WE is high for exactly one cycle per write and only in ACCESS. DEV_WD and DEV_ADD are stable through ACCESS.
- PrRD holds its value until the next read completes.
- IRQ edge to HWInt: edge sampled at posedge t sets pending at t; HWInt is high after t (registered pending, combinational mask AND).
- An ACK write clears pending at the ACCESS edge. HWInt falls in the RESP cycle.

## Test plan
- Reset then idle: after clr=0 for 2 cycles, then clr=1, every output is 0. PrReady stays 0 with no request.
- Timer write: PrWE=1, PrAddr=0x7F14, PrWD=0x64. DEV1_WE pulses 1 cycle later with DEV_ADD=1, DEV_WD=0x64. DEV0_WE stays 0. PrReady pulses at t+2.
- Timer read: DEV0_RD=0x1234 with PrAddr=0x7F08, PrRE=1. PrRD=0x0000_1234 with PrReady at t+2.
- Interrupt flow:
  - MASK<=0x3, then raise DEV0_IRQ and hold it: HWInt=6'b000001.
  - Write ACK=0x1: HWInt=0 and stays 0 while DEV0_IRQ remains high.
  - Drop and re-raise DEV0_IRQ: HWInt=1 again.
- Masked and simultaneous events:
  - With MASK=0, pulse DEV1_IRQ: STATUS reads 0x2 and HWInt=0. Setting MASK=0x2 gives HWInt=6'b000010.
  - Edge on the same cycle as ACK=0x2: pending[1] stays 1.
- Unmapped access: read of 0x7F30 returns PrRD=0 with PrReady and no DEVn_WE. STATUS reads 0x100. ACK=0x100 clears it to 0.

Source files
------------

// File: rtl/timer_bridge_if.sv
// CPU-side peripheral bus between the memory stage and timer_bridge.
// The CPU drives the request fields; the bridge returns read data and the completion pulse.
interface timer_bridge_if;
    logic [31:0] PrAddr;
    logic [31:0] PrWD;
    logic        PrRE;
    logic        PrWE;
    logic [31:0] PrRD;
    logic        PrReady;

    modport master (
        output PrAddr, PrWD, PrRE, PrWE,
        input  PrRD, PrReady
    );

    modport slave (
        input  PrAddr, PrWD, PrRE, PrWE,
        output PrRD, PrReady
    );
endinterface

// File: rtl/timer_bridge.sv
// Sequences CPU peripheral accesses onto two timers as fixed 3-cycle transactions and
// latches timer IRQ edges into a maskable pending register that drives HWInt.
module timer_bridge #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic          clk,
    input  logic          clr,
    timer_bridge_if.slave pr,
    output logic [31:0]   DEV_WD,
    output logic [1:0]    DEV_ADD,
    output logic          DEV0_WE,
    output logic          DEV1_WE,
    input  logic [31:0]   DEV0_RD,
    input  logic [31:0]   DEV1_RD,
    input  logic          DEV0_IRQ,
    input  logic          DEV1_IRQ,
    output logic [5:0]    HWInt
);
    // state  | meaning
    // IDLE   | waiting for PrWE/PrRE; request fields latched on accept
    // ACCESS | timer strobe or read capture, internal register access
    // RESP   | PrReady pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [2:0] {TGT_DEV0, TGT_DEV1, TGT_STATUS, TGT_MASK, TGT_ACK, TGT_NONE} tgt_t;

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d, tgt_dec;
    logic        we_q, we_d;
    logic [1:0]  add_q, add_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic [1:0]  irq_q, irq_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  mask_q, mask_d;
    logic        err_q, err_d;
    logic [1:0]  irq_in, ack_clr;
    logic        accept, acc_en;

    assign irq_in = {DEV1_IRQ, DEV0_IRQ};

    always_comb begin
        tgt_dec = TGT_NONE;
        if (pr.PrAddr[31:6] == BASE[31:6]) begin
            case (pr.PrAddr[5:2])
                4'h0, 4'h1, 4'h2: tgt_dec = TGT_DEV0;
                4'h4, 4'h5, 4'h6: tgt_dec = TGT_DEV1;
                4'h8:             tgt_dec = TGT_STATUS;
                4'h9:             tgt_dec = TGT_MASK;
                4'hA:             tgt_dec = TGT_ACK;
                default:          tgt_dec = TGT_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pr.PrWE || pr.PrRE) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe and ready are gated by clr so a reset landing mid-transaction emits nothing.
    always_comb begin
        accept     = (state_q == IDLE) && (pr.PrWE || pr.PrRE);
        acc_en     = clr && (state_q == ACCESS);
        DEV0_WE    = acc_en && we_q && (tgt_q == TGT_DEV0);
        DEV1_WE    = acc_en && we_q && (tgt_q == TGT_DEV1);
        pr.PrReady = clr && (state_q == RESP);
        pr.PrRD    = rd_q;
        DEV_WD     = wd_q;
        DEV_ADD    = add_q;
        HWInt      = {4'b0000, pend_q & mask_q};
    end

    always_comb begin
        we_d    = we_q;
        tgt_d   = tgt_q;
        add_d   = add_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        mask_d  = mask_q;
        err_d   = err_q;
        ack_clr = 2'b00;
        if (accept) begin
            we_d  = pr.PrWE;
            tgt_d = tgt_dec;
            add_d = pr.PrAddr[3:2];
            wd_d  = pr.PrWD;
        end
        if (acc_en) begin
            case (tgt_q)
                TGT_DEV0:   if (!we_q) rd_d = DEV0_RD;
                TGT_DEV1:   if (!we_q) rd_d = DEV1_RD;
                TGT_STATUS: if (!we_q) rd_d = {23'd0, err_q, 6'd0, pend_q};
                TGT_MASK: begin
                    if (we_q) mask_d = wd_q[1:0];
                    else      rd_d   = {30'd0, mask_q};
                end
                TGT_ACK: begin
                    if (we_q) begin
                        ack_clr = wd_q[1:0];
                        if (wd_q[8]) err_d = 1'b0;
                    end else begin
                        rd_d = 32'd0;
                    end
                end
                default: begin
                    err_d = 1'b1;
                    if (!we_q) rd_d = 32'd0;
                end
            endcase
        end
        irq_d  = irq_in;
        // A new edge outranks an acknowledge in the same cycle.
        pend_d = (pend_q & ~ack_clr) | (irq_in & ~irq_q);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            we_q   <= 1'b0;
            tgt_q  <= TGT_NONE;
            add_q  <= 2'b00;
            wd_q   <= 32'd0;
            rd_q   <= 32'd0;
            irq_q  <= 2'b00;
            pend_q <= 2'b00;
            mask_q <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            tgt_q  <= tgt_d;
            add_q  <= add_d;
            wd_q   <= wd_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_timer_bridge.sv
// Self-checking bench for timer_bridge: directed plan steps, then random accesses and IRQ
// activity compared against an address-map / pending-register model.
module tb_timer_bridge;
    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] dev0_rd, dev1_rd, dev_wd;
    logic [1:0]  dev_add;
    logic        dev0_we, dev1_we, dev0_irq, dev1_irq;
    logic [5:0]  hwint;

    timer_bridge_if pr_bus();

    timer_bridge #(.BASE(BASE)) dut (
        .clk      (clk),
        .clr      (clr),
        .pr       (pr_bus),
        .DEV_WD   (dev_wd),
        .DEV_ADD  (dev_add),
        .DEV0_WE  (dev0_we),
        .DEV1_WE  (dev1_we),
        .DEV0_RD  (dev0_rd),
        .DEV1_RD  (dev1_rd),
        .DEV0_IRQ (dev0_irq),
        .DEV1_IRQ (dev1_irq),
        .HWInt    (hwint)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]  pend_m, mask_m, irq_seen, irq_now;
    logic        err_m;
    logic [31:0] prrd_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_irq(input logic [1:0] v);
        irq_now  = v;
        dev0_irq = v[0];
        dev1_irq = v[1];
    endtask

    // One clock; the model applies reset, IRQ edges and any acknowledge landing on this edge.
    task automatic tick(input logic [1:0] ack);
        @(posedge clk);
        if (!clr) begin
            pend_m   = 2'b00;
            mask_m   = 2'b00;
            err_m    = 1'b0;
            prrd_m   = 32'd0;
            irq_seen = 2'b00;
        end else begin
            pend_m   = (pend_m & ~ack) | (irq_now & ~irq_seen);
            irq_seen = irq_now;
        end
        #1;
    endtask

    function automatic logic [31:0] hw_exp();
        return {30'd0, pend_m & mask_m};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd"},   pr_bus.PrRD, 32'd0);
        chk({tag, "_rdy"},  32'(pr_bus.PrReady), 32'd0);
        chk({tag, "_we"},   32'({dev1_we, dev0_we}), 32'd0);
        chk({tag, "_add"},  32'(dev_add), 32'd0);
        chk({tag, "_wd"},   dev_wd, 32'd0);
        chk({tag, "_hw"},   32'(hwint), 32'd0);
    endtask

    // Full request/response; irq_acc is applied so its edge coincides with the ACCESS edge.
    task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] irq_acc);
        logic [31:0] off, rd_exp;
        logic [1:0]  ack;
        bit          win, t0, t1, st, mk, ak;
        win = (addr >= BASE) && (addr <= BASE + 32'd63);
        off = (addr - BASE) & 32'hFFFF_FFFC;
        t0  = win && (off < 32'h0C);
        t1  = win && (off >= 32'h10) && (off < 32'h1C);
        st  = win && (off == 32'h20);
        mk  = win && (off == 32'h24);
        ak  = win && (off == 32'h28);
        ack = (we && ak) ? wd[1:0] : 2'b00;

        pr_bus.PrAddr = addr;
        pr_bus.PrWD   = wd;
        pr_bus.PrWE   = we;
        pr_bus.PrRE   = !we;
        tick(2'b00);

        rd_exp = prrd_m;
        if (!we) begin
            if (t0)      rd_exp = dev0_rd;
            else if (t1) rd_exp = dev1_rd;
            else if (st) rd_exp = {23'd0, err_m, 6'd0, pend_m};
            else if (mk) rd_exp = {30'd0, mask_m};
            else         rd_exp = 32'd0;
        end
        set_irq(irq_acc);
        chk("acc_we0", 32'(dev0_we), 32'(we && t0));
        chk("acc_we1", 32'(dev1_we), 32'(we && t1));
        chk("acc_add", 32'(dev_add), 32'(addr[3:2]));
        chk("acc_wd",  dev_wd, wd);
        chk("acc_rdy", 32'(pr_bus.PrReady), 32'd0);

        tick(ack);
        if (we && mk) mask_m = wd[1:0];
        if (we && ak && wd[8]) err_m = 1'b0;
        if (!(t0 || t1 || st || mk || ak)) err_m = 1'b1;
        prrd_m = rd_exp;
        chk("resp_rdy", 32'(pr_bus.PrReady), 32'd1);
        chk("resp_we",  32'({dev1_we, dev0_we}), 32'd0);
        chk("resp_rd",  pr_bus.PrRD, prrd_m);
        chk("resp_hw",  32'(hwint), hw_exp());

        pr_bus.PrWE = 1'b0;
        pr_bus.PrRE = 1'b0;
        tick(2'b00);
        chk("idle_rdy", 32'(pr_bus.PrReady), 32'd0);
        chk("idle_rd",  pr_bus.PrRD, prrd_m);
    endtask

    logic [5:0]  holes [7] = '{6'h0C, 6'h1C, 6'h2C, 6'h30, 6'h34, 6'h38, 6'h3C};
    logic [31:0] a, w;
    int          cat;

    initial begin
        clr = 1'b0;
        pr_bus.PrAddr = 32'd0;
        pr_bus.PrWD   = 32'd0;
        pr_bus.PrWE   = 1'b0;
        pr_bus.PrRE   = 1'b0;
        dev0_rd = 32'd0;
        dev1_rd = 32'd0;
        set_irq(2'b00);
        pend_m = 2'b00; mask_m = 2'b00; err_m = 1'b0; prrd_m = 32'd0; irq_seen = 2'b00;

        tick(2'b00);
        tick(2'b00);
        check_idle_outputs("rst");
        clr = 1'b1;
        tick(2'b00);
        check_idle_outputs("post_rst");
        tick(2'b00);
        tick(2'b00);
        chk("no_req_rdy", 32'(pr_bus.PrReady), 32'd0);

        // Timer write and read from the plan.
        bus(1'b1, 32'h0000_7F14, 32'h64, irq_now);
        dev0_rd = 32'h1234;
        bus(1'b0, 32'h0000_7F08, 32'd0, irq_now);
        chk("plan_rd", pr_bus.PrRD, 32'h0000_1234);
        bus(1'b1, 32'h0000_7F08, 32'hCAFE, irq_now);

        // Interrupt flow.
        bus(1'b1, BASE + 32'h24, 32'h3, irq_now);
        set_irq(2'b01);
        tick(2'b00);
        chk("irq0_hw", 32'(hwint), 32'h01);
        tick(2'b00);
        chk("irq0_hold", 32'(hwint), hw_exp());
        bus(1'b1, BASE + 32'h28, 32'h1, irq_now);
        chk("ack0_hw", 32'(hwint), 32'h00);
        tick(2'b00);
        tick(2'b00);
        chk("ack0_held", 32'(hwint), 32'h00);
        set_irq(2'b00);
        tick(2'b00);
        set_irq(2'b01);
        tick(2'b00);
        chk("reraise_hw", 32'(hwint), 32'h01);

        // Masked pending, then unmask; then edge coinciding with ACK.
        bus(1'b1, BASE + 32'h28, 32'h3, irq_now);
        bus(1'b1, BASE + 32'h24, 32'h0, irq_now);
        set_irq(2'b11);
        tick(2'b00);
        set_irq(2'b01);
        tick(2'b00);
        chk("masked_hw", 32'(hwint), 32'h00);
        bus(1'b0, BASE + 32'h20, 32'd0, irq_now);
        chk("masked_status", pr_bus.PrRD, 32'h2);
        bus(1'b1, BASE + 32'h24, 32'h2, irq_now);
        chk("unmask_hw", 32'(hwint), 32'h02);
        bus(1'b1, BASE + 32'h28, 32'h2, 2'b11);
        bus(1'b0, BASE + 32'h20, 32'd0, irq_now);
        chk("set_wins", pr_bus.PrRD, 32'h2);

        // Unmapped access and err flag.
        bus(1'b1, BASE + 32'h28, 32'h3, irq_now);
        dev0_rd = 32'hDEAD_BEEF;
        bus(1'b0, BASE + 32'h04, 32'd0, irq_now);
        bus(1'b0, 32'h0000_7F30, 32'd0, irq_now);
        chk("unmapped_rd", pr_bus.PrRD, 32'd0);
        bus(1'b0, BASE + 32'h20, 32'd0, irq_now);
        chk("err_status", pr_bus.PrRD, 32'h100);
        bus(1'b1, BASE + 32'h28, 32'h100, irq_now);
        bus(1'b0, BASE + 32'h20, 32'd0, irq_now);
        chk("err_cleared", pr_bus.PrRD, 32'h0);

        // Reset while in ACCESS: no strobe, no ready.
        pr_bus.PrAddr = BASE + 32'h04;
        pr_bus.PrWD   = 32'h55;
        pr_bus.PrWE   = 1'b1;
        tick(2'b00);
        clr = 1'b0;
        pr_bus.PrWE = 1'b0;
        #1;
        chk("abort_we", 32'({dev1_we, dev0_we}), 32'd0);
        chk("abort_rdy", 32'(pr_bus.PrReady), 32'd0);
        tick(2'b00);
        set_irq(2'b00);
        tick(2'b00);
        clr = 1'b1;
        check_idle_outputs("abort");
        tick(2'b00);
        chk("abort_rdy2", 32'(pr_bus.PrReady), 32'd0);
        tick(2'b00);
        chk("abort_rdy3", 32'(pr_bus.PrReady), 32'd0);

        // Random accesses with interleaved IRQ activity.
        for (int i = 0; i < 200; i++) begin
            dev0_rd = $urandom;
            dev1_rd = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                set_irq(2'($urandom_range(0, 3)));
                tick(2'b00);
                chk("rnd_idle_hw", 32'(hwint), hw_exp());
            end
            cat = $urandom_range(0, 6);
            w   = $urandom;
            case (cat)
                0:       a = BASE + 32'(4 * $urandom_range(0, 2));
                1:       a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 2));
                2:       a = BASE + 32'h20;
                3:       a = BASE + 32'h24;
                4:       a = BASE + 32'h28;
                5:       a = BASE + 32'(holes[$urandom_range(0, 6)]);
                default: begin
                    a = $urandom;
                    if (a[31:6] == BASE[31:6]) a[20] = ~a[20];
                end
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            if (cat == 2)      bus(1'b0, a, w, 2'($urandom_range(0, 3)));
            else if (cat == 4) bus(1'b1, a, w, 2'($urandom_range(0, 3)));
            else               bus(1'($urandom_range(0, 1)), a, w, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
